// File: rtl/wl_ctrl_pkg.sv
// Shared types and constants for the wordline pulse controller.
//   wl_state_t : controller sequence states
//   CNT_W      : width of the shared PRE/DRIVE down-counter
package wl_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DRIVE,
    ST_REC
  } wl_state_t;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/wl_onehot_dec.sv
// Combinational row decoder: one-hot select of the addressed row, or all
// zero when disabled or when the address is beyond the last row.
//   en  : decode enable
//   adr : row address
//   wl  : one-hot / zero row select
module wl_onehot_dec #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned ADR_W = $clog2(ROWS)
) (
  input  logic             en,
  input  logic [ADR_W-1:0] adr,
  output logic [ROWS-1:0]  wl
);

  // Rows that do not exist never match, so out-of-range decodes to zero.
  always_comb begin
    wl = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (en && (adr == ADR_W'(i))) wl[i] = 1'b1;
    end
  end

endmodule

// File: rtl/wl_pulse_ctrl.sv
// Wordline pulse controller: accepts row-access commands over ready/valid,
// keeps one command active and one buffered, and runs each through
// precharge -> drive -> recovery, routing IN onto WL[ADR] or onto WB.
//   clk, rst     : clock, synchronous active-high reset
//   req / ready  : command handshake (transfer on req && ready)
//   in, sel_wb,
//   adr          : command payload (level, WB target, row address)
//   wl, wb       : driven row lines / write-bit line
//   pre          : precharge enable
//   done, err    : end-of-command pulse, out-of-range address flag
module wl_pulse_ctrl
  import wl_ctrl_pkg::*;
#(
  parameter int unsigned ROWS      = 16,
  parameter int unsigned ADR_W     = $clog2(ROWS),
  parameter int unsigned PRE_CYC   = 1,
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             ready,
  input  logic             in,
  input  logic             sel_wb,
  input  logic [ADR_W-1:0] adr,
  output logic [ROWS-1:0]  wl,
  output logic             wb,
  output logic             pre,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [ADR_W:0]   ROW_LIM  = (ADR_W + 1)'(ROWS);

  wl_state_t        state;
  logic [CNT_W-1:0] cnt;

  logic             cur_in;
  logic             cur_sel;
  logic [ADR_W-1:0] cur_adr;

  logic             pend_vld;
  logic             pend_in;
  logic             pend_sel;
  logic [ADR_W-1:0] pend_adr;

  logic             xfer;
  logic             start;
  logic             pend_load;
  logic             pend_drain;
  logic             cur_oor;

  // Command about to enter DRIVE (or be launched) and its decoded lines.
  logic             l_in;
  logic             l_sel;
  logic [ADR_W-1:0] l_adr;
  logic             l_wb;
  logic [ROWS-1:0]  dec_wl;

  assign xfer       = req & ready;
  assign pend_drain = (state == ST_REC) & pend_vld;
  // A new command launches from IDLE, or straight out of REC (buffered first).
  assign start      = ((state == ST_IDLE) & xfer) |
                      ((state == ST_REC) & (pend_vld | xfer));
  assign pend_load  = xfer & ((state == ST_PRE) | (state == ST_DRIVE));
  assign cur_oor    = ~cur_sel & ({1'b0, cur_adr} >= ROW_LIM);

  // Select which command the decoder sees: the active one when leaving PRE,
  // the buffered one when it is launched from REC, otherwise the input.
  always_comb begin
    l_in  = in;
    l_sel = sel_wb;
    l_adr = adr;
    if (state == ST_PRE) begin
      l_in  = cur_in;
      l_sel = cur_sel;
      l_adr = cur_adr;
    end else if (pend_drain) begin
      l_in  = pend_in;
      l_sel = pend_sel;
      l_adr = pend_adr;
    end
  end

  assign l_wb = l_in & l_sel;

  wl_onehot_dec #(
    .ROWS  (ROWS),
    .ADR_W (ADR_W)
  ) u_dec (
    .en  (l_in & ~l_sel),
    .adr (l_adr),
    .wl  (dec_wl)
  );

  // Sequencer, command storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur_in   <= 1'b0;
      cur_sel  <= 1'b0;
      cur_adr  <= '0;
      pend_vld <= 1'b0;
      pend_in  <= 1'b0;
      pend_sel <= 1'b0;
      pend_adr <= '0;
      ready    <= 1'b0;
      wl       <= '0;
      wb       <= 1'b0;
      pre      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ready <= ~pend_vld;
      wl    <= '0;
      wb    <= 1'b0;
      pre   <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;

      if (pend_load) begin
        pend_vld <= 1'b1;
        pend_in  <= in;
        pend_sel <= sel_wb;
        pend_adr <= adr;
        ready    <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
        end
        ST_PRE: begin
          if (cnt == '0) begin
            state <= ST_DRIVE;
            cnt   <= PULSE_LD;
            wl    <= dec_wl;
            wb    <= l_wb;
          end else begin
            cnt <= cnt - CNT_W'(1);
            pre <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt == '0) begin
            state <= ST_REC;
            done  <= 1'b1;
            err   <= cur_oor;
          end else begin
            cnt <= cnt - CNT_W'(1);
            wl  <= wl;
            wb  <= wb;
          end
        end
        ST_REC: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Launch overrides the state update above.
      if (start) begin
        cur_in  <= l_in;
        cur_sel <= l_sel;
        cur_adr <= l_adr;
        if (pend_drain) begin
          pend_vld <= 1'b0;
          ready    <= 1'b1;
        end
        if (PRE_CYC == 0) begin
          state <= ST_DRIVE;
          cnt   <= PULSE_LD;
          wl    <= dec_wl;
          wb    <= l_wb;
        end else begin
          state <= ST_PRE;
          cnt   <= PRE_LD;
          pre   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wl_pulse_ctrl.sv
// Bench for wl_pulse_ctrl: two instances (ROWS=16/PRE=1/PULSE=2 and
// ROWS=12/PRE=0/PULSE=1) checked every cycle against a command-schedule
// model, plus table-driven and hand-written sequences.
module tb_wl_pulse_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, in_a, sel_a;
  logic [3:0]  adr_a;
  logic        ready_a, wb_a, pre_a, done_a, err_a;
  logic [15:0] wl_a;
  logic        req_b, in_b, sel_b;
  logic [3:0]  adr_b;
  logic        ready_b, wb_b, pre_b, done_b, err_b;
  logic [11:0] wl_b;

  wl_pulse_ctrl #(.ROWS(16), .PRE_CYC(1), .PULSE_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .ready(ready_a), .in(in_a),
    .sel_wb(sel_a), .adr(adr_a), .wl(wl_a), .wb(wb_a), .pre(pre_a),
    .done(done_a), .err(err_a)
  );

  wl_pulse_ctrl #(.ROWS(12), .PRE_CYC(0), .PULSE_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .ready(ready_b), .in(in_b),
    .sel_wb(sel_b), .adr(adr_b), .wl(wl_b), .wb(wb_b), .pre(pre_b),
    .done(done_b), .err(err_b)
  );

  int total, bad, ecnt;

  // Schedule model: each accepted command gets a start edge s; after edge
  // s+j it is in precharge for j<PRE, drives for the next PULSE edges, and
  // recovers on the last. Starts never overlap: s = max(accept, prev end).
  int          rows_p[2], pre_p[2], pul_p[2];
  int          nsch[2];
  int          sch_s[2][4];
  logic        sch_in[2][4];
  logic        sch_sel[2][4];
  int          sch_adr[2][4];
  int          busy[2];
  logic        rdy[2];
  logic [15:0] x_wl[2];
  logic        x_wb[2], x_pre[2], x_done[2], x_err[2];

  typedef struct {
    logic        in;
    logic        sel;
    logic [3:0]  adr;
    logic [15:0] wl;
    logic        wb;
    logic        err;
  } vec_t;
  vec_t vecs[6];

  logic [15:0] b2b_wl[6];
  logic        b2b_pre[6], b2b_done[6], b2b_rdy[6];

  int          sent, nd, cyc;
  logic        acc;
  logic [5:0]  idx;

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %b want %b (edge %0d)", nm, act, exp_v, ecnt);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp_v, ecnt);
    end
  endtask

  task automatic model_edge(input int d, input logic rq, input logic ii,
                            input logic ss, input logic [3:0] aa);
    int p, s, j, k;
    p = pre_p[d] + pul_p[d] + 1;
    x_wl[d] = '0; x_wb[d] = 1'b0; x_pre[d] = 1'b0; x_done[d] = 1'b0; x_err[d] = 1'b0;
    if (rst) begin
      nsch[d] = 0; busy[d] = 0; rdy[d] = 1'b0;
      return;
    end
    if (rq && rdy[d]) begin
      s = (busy[d] > ecnt) ? busy[d] : ecnt;
      sch_s[d][nsch[d]]   = s;
      sch_in[d][nsch[d]]  = ii;
      sch_sel[d][nsch[d]] = ss;
      sch_adr[d][nsch[d]] = int'(aa);
      nsch[d]++;
      busy[d] = s + p;
    end
    k = 0;
    for (int i = 0; i < nsch[d]; i++) begin
      if (sch_s[d][i] + p - 1 >= ecnt) begin
        sch_s[d][k] = sch_s[d][i]; sch_in[d][k] = sch_in[d][i];
        sch_sel[d][k] = sch_sel[d][i]; sch_adr[d][k] = sch_adr[d][i];
        k++;
      end
    end
    nsch[d] = k;
    rdy[d] = 1'b1;
    for (int i = 0; i < nsch[d]; i++) begin
      if (sch_s[d][i] > ecnt) begin
        rdy[d] = 1'b0;
      end else begin
        j = ecnt - sch_s[d][i];
        if (j < pre_p[d]) begin
          x_pre[d] = 1'b1;
        end else if (j < pre_p[d] + pul_p[d]) begin
          if (sch_in[d][i] && !sch_sel[d][i] && sch_adr[d][i] < rows_p[d])
            x_wl[d] = 16'(1) << sch_adr[d][i];
          if (sch_in[d][i] && sch_sel[d][i]) x_wb[d] = 1'b1;
        end else begin
          x_done[d] = 1'b1;
          x_err[d]  = !sch_sel[d][i] && (sch_adr[d][i] >= rows_p[d]);
        end
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [15:0] wl, input logic wb,
                           input logic pr, input logic dn, input logic er,
                           input logic rd);
    string p;
    p = (d == 0) ? "a" : "b";
    chk16({p, ".wl"}, wl, x_wl[d]);
    chk1({p, ".wb"}, wb, x_wb[d]);
    chk1({p, ".pre"}, pr, x_pre[d]);
    chk1({p, ".done"}, dn, x_done[d]);
    chk1({p, ".err"}, er, x_err[d]);
    chk1({p, ".ready"}, rd, rdy[d]);
    chk1({p, ".onehot"}, $onehot0({wl, wb}), 1'b1);
    chk1({p, ".excl"}, pr && (|{wl, wb}), 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, req_a, in_a, sel_a, adr_a);
    model_edge(1, req_b, in_b, sel_b, adr_b);
    ecnt++;
    #1;
    check_dut(0, wl_a, wb_a, pre_a, done_a, err_a, ready_a);
    check_dut(1, {4'b0, wl_b}, wb_b, pre_b, done_b, err_b, ready_b);
  endtask

  initial begin
    total = 0; bad = 0; ecnt = 0;
    rows_p[0] = 16; pre_p[0] = 1; pul_p[0] = 2;
    rows_p[1] = 12; pre_p[1] = 0; pul_p[1] = 1;
    for (int d = 0; d < 2; d++) begin
      nsch[d] = 0; busy[d] = 0; rdy[d] = 1'b0;
    end

    vecs[0] = '{1'b1, 1'b0, 4'd9,  16'h0200, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'd3,  16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 4'd5,  16'h0000, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'd0,  16'h0001, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 4'd15, 16'h8000, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 4'd7,  16'h0000, 1'b0, 1'b0};

    // Back-to-back expectations for cycles 3..8.
    b2b_wl[0] = 16'h0001; b2b_wl[1] = 16'h0000; b2b_wl[2] = 16'h0000;
    b2b_wl[3] = 16'h8000; b2b_wl[4] = 16'h8000; b2b_wl[5] = 16'h0000;
    b2b_pre[0] = 1'b0; b2b_pre[1] = 1'b0; b2b_pre[2] = 1'b1;
    b2b_pre[3] = 1'b0; b2b_pre[4] = 1'b0; b2b_pre[5] = 1'b0;
    b2b_done[0] = 1'b0; b2b_done[1] = 1'b1; b2b_done[2] = 1'b0;
    b2b_done[3] = 1'b0; b2b_done[4] = 1'b0; b2b_done[5] = 1'b1;
    b2b_rdy[0] = 1'b0; b2b_rdy[1] = 1'b0; b2b_rdy[2] = 1'b1;
    b2b_rdy[3] = 1'b1; b2b_rdy[4] = 1'b1; b2b_rdy[5] = 1'b1;

    req_a = 1'b0; in_a = 1'b0; sel_a = 1'b0; adr_a = '0;
    req_b = 1'b0; in_b = 1'b0; sel_b = 1'b0; adr_b = '0;

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    chk1("rst.ready_low", ready_a, 1'b0);
    chk16("rst.wl", wl_a, 16'h0000);
    rst = 1'b0;
    step();
    chk1("rst.ready_up", ready_a, 1'b1);

    // Single commands from the table.
    for (int v = 0; v < 6; v++) begin
      in_a = vecs[v].in; sel_a = vecs[v].sel; adr_a = vecs[v].adr; req_a = 1'b1;
      step();
      req_a = 1'b0;
      chk1("vec.pre", pre_a, 1'b1);
      chk16("vec.wl_pre", wl_a, 16'h0000);
      repeat (2) begin
        step();
        chk16("vec.wl", wl_a, vecs[v].wl);
        chk1("vec.wb", wb_a, vecs[v].wb);
        chk1("vec.pre_off", pre_a, 1'b0);
      end
      step();
      chk1("vec.done", done_a, 1'b1);
      chk1("vec.err", err_a, vecs[v].err);
      step();
      chk1("vec.idle_done", done_a, 1'b0);
      chk1("vec.idle_pre", pre_a, 1'b0);
      chk1("vec.idle_ready", ready_a, 1'b1);
    end

    // Back-to-back: ADR 0 then ADR 15 on the next edge.
    in_a = 1'b1; sel_a = 1'b0; adr_a = 4'd0; req_a = 1'b1;
    step();
    adr_a = 4'd15;
    step();
    req_a = 1'b0;
    chk1("b2b.ready_c2", ready_a, 1'b0);
    chk16("b2b.wl_c2", wl_a, 16'h0001);
    for (int c = 0; c < 6; c++) begin
      step();
      chk16("b2b.wl", wl_a, b2b_wl[c]);
      chk1("b2b.pre", pre_a, b2b_pre[c]);
      chk1("b2b.done", done_a, b2b_done[c]);
      chk1("b2b.ready", ready_a, b2b_rdy[c]);
    end

    // Reset mid-DRIVE on WL[5].
    in_a = 1'b1; sel_a = 1'b0; adr_a = 4'd5; req_a = 1'b1;
    step();
    req_a = 1'b0;
    step();
    chk16("mrst.wl_drive", wl_a, 16'h0020);
    rst = 1'b1;
    repeat (3) begin
      step();
      chk16("mrst.wl", wl_a, 16'h0000);
      chk1("mrst.pre", pre_a, 1'b0);
      chk1("mrst.done", done_a, 1'b0);
      chk1("mrst.ready", ready_a, 1'b0);
    end
    rst = 1'b0;
    step();
    chk1("mrst.ready_up", ready_a, 1'b1);
    repeat (4) begin
      step();
      chk1("mrst.no_done", done_a, 1'b0);
      chk16("mrst.wl_after", wl_a, 16'h0000);
    end

    // ROWS=12, no precharge: out-of-range row then a command issued in REC.
    in_b = 1'b1; sel_b = 1'b0; adr_b = 4'd13; req_b = 1'b1;
    step();
    req_b = 1'b0;
    chk16("b.oor_wl", {4'b0, wl_b}, 16'h0000);
    chk1("b.oor_pre", pre_b, 1'b0);
    step();
    chk1("b.oor_done", done_b, 1'b1);
    chk1("b.oor_err", err_b, 1'b1);
    adr_b = 4'd2; req_b = 1'b1;
    step();
    req_b = 1'b0;
    chk16("b.rec_wl", {4'b0, wl_b}, 16'h0004);
    step();
    chk1("b.rec_done", done_b, 1'b1);
    chk1("b.rec_err", err_b, 1'b0);
    step();

    // Exhaustive sweep on instance A with sustained REQ.
    sent = 0; nd = 0; cyc = 0;
    while (sent < 64 && cyc < 1000) begin
      idx = 6'(sent);
      in_a = idx[5]; sel_a = idx[4]; adr_a = idx[3:0]; req_a = 1'b1;
      acc = rdy[0];
      step();
      if (acc) sent++;
      if (done_a) nd++;
      cyc++;
    end
    req_a = 1'b0;
    repeat (12) begin
      step();
      if (done_a) nd++;
    end
    chk16("sweep.sent", 16'(sent), 16'(64));
    chk16("sweep.dones", 16'(nd), 16'(64));

    // Random traffic on both instances with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 249) == 0);
      req_a = 1'($urandom_range(0, 1));
      in_a  = 1'($urandom_range(0, 1));
      sel_a = 1'($urandom_range(0, 1));
      adr_a = 4'($urandom_range(0, 15));
      req_b = 1'($urandom_range(0, 1));
      in_b  = 1'($urandom_range(0, 1));
      sel_b = 1'($urandom_range(0, 1));
      adr_b = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
